// File: rtl/conversor_bin2bcd_secuencial_if.sv
// Handshake bundle between the ALU result path and the binary-to-BCD converter.
//   iniciar          : start request (master -> converter)
//   entrada          : unsigned binary operand (master -> converter)
//   habilitar_salida : output enable for salida_bcd (master -> converter)
//   salida_bcd       : packed BCD result, digit 0 in bits [3:0] (converter -> master)
//   ocupado          : conversion in progress (converter -> master)
//   listo            : one-cycle pulse when a new result is latched (converter -> master)
//   desbordamiento   : last accepted operand was saturated (converter -> master)
interface conversor_bin2bcd_secuencial_if #(
    parameter int ANCHO_BIN = 14,
    parameter int DIGITOS   = 4
);
    logic                   iniciar;
    logic [ANCHO_BIN-1:0]   entrada;
    logic                   habilitar_salida;
    logic [4*DIGITOS-1:0]   salida_bcd;
    logic                   ocupado;
    logic                   listo;
    logic                   desbordamiento;

    modport master (
        output iniciar, entrada, habilitar_salida,
        input  salida_bcd, ocupado, listo, desbordamiento
    );

    modport slave (
        input  iniciar, entrada, habilitar_salida,
        output salida_bcd, ocupado, listo, desbordamiento
    );
endinterface

// File: rtl/conversor_bin2bcd_secuencial.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per falling edge).
// Ports:
//   reloj : clock, all registers update on the falling edge
//   reset : synchronous, active-high
//   bus   : slave side of conversor_bin2bcd_secuencial_if (iniciar, entrada,
//           habilitar_salida in; salida_bcd, ocupado, listo, desbordamiento out)
//
// state      | meaning
// -----------+------------------------------------------------
// REPOSO     | idle, waiting for iniciar
// DESPLAZAR  | shifting, ANCHO_BIN edges
// LISTO      | result latched, listo high for this cycle only
module conversor_bin2bcd_secuencial #(
    parameter int ANCHO_BIN = 14,
    parameter int DIGITOS   = 4
) (
    input logic reloj,
    input logic reset,
    conversor_bin2bcd_secuencial_if.slave bus
);
    function automatic longint unsigned pot10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int              AB      = 4 * DIGITOS;
    localparam int              AT      = AB + ANCHO_BIN;
    localparam int              AC      = $clog2(ANCHO_BIN + 1);
    localparam longint unsigned LIMITE  = pot10(DIGITOS) - 1;
    localparam longint unsigned MAX_BIN = (64'd1 << ANCHO_BIN) - 1;
    localparam bit              RECORTE = (MAX_BIN > LIMITE);

    typedef enum logic [1:0] {REPOSO, DESPLAZAR, LISTO} estado_t;

    estado_t              estado;
    logic [AT-1:0]        dd;          // {scratch BCD, binary operand}
    logic [AC-1:0]        contador;
    logic [AB-1:0]        salida_reg;
    logic                 desb_int;
    logic                 desb_reg;
    logic                 listo_reg;
    logic                 ocupado_reg;
    logic                 excede;
    logic [ANCHO_BIN-1:0] entrada_rec;
    logic [AB-1:0]        ajustado;
    logic [AT-1:0]        siguiente;

    // The clamp keeps the operand within DIGITOS digits, so the scratch never
    // carries out of its top digit.
    generate
        if (RECORTE) begin : g_recorte
            localparam logic [ANCHO_BIN-1:0] LIMITE_BIN = ANCHO_BIN'(LIMITE);
            assign excede      = (64'(bus.entrada) > LIMITE);
            assign entrada_rec = excede ? LIMITE_BIN : bus.entrada;
        end else begin : g_sin_recorte
            assign excede      = 1'b0;
            assign entrada_rec = bus.entrada;
        end
    endgenerate

    always_comb begin
        ajustado = dd[AT-1:ANCHO_BIN];
        for (int d = 0; d < DIGITOS; d++) begin
            if (dd[ANCHO_BIN + 4*d +: 4] >= 4'd5)
                ajustado[4*d +: 4] = dd[ANCHO_BIN + 4*d +: 4] + 4'd3;
        end
    end

    assign siguiente = {ajustado, dd[ANCHO_BIN-1:0]} << 1;

    always_ff @(negedge reloj) begin
        if (reset) begin
            estado      <= REPOSO;
            dd          <= '0;
            contador    <= '0;
            salida_reg  <= '0;
            desb_int    <= 1'b0;
            desb_reg    <= 1'b0;
            listo_reg   <= 1'b0;
            ocupado_reg <= 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    listo_reg <= 1'b0;
                    if (bus.iniciar) begin
                        dd          <= {{AB{1'b0}}, entrada_rec};
                        desb_int    <= excede;
                        contador    <= AC'(ANCHO_BIN);
                        ocupado_reg <= 1'b1;
                        estado      <= DESPLAZAR;
                    end
                end
                DESPLAZAR: begin
                    dd       <= siguiente;
                    contador <= contador - AC'(1);
                    if (contador == AC'(1)) begin
                        salida_reg <= siguiente[AT-1:ANCHO_BIN];
                        desb_reg   <= desb_int;
                        listo_reg  <= 1'b1;
                        estado     <= LISTO;
                    end
                end
                LISTO: begin
                    listo_reg   <= 1'b0;
                    ocupado_reg <= 1'b0;
                    estado      <= REPOSO;
                end
                default: begin
                    listo_reg   <= 1'b0;
                    ocupado_reg <= 1'b0;
                    estado      <= REPOSO;
                end
            endcase
        end
    end

    assign bus.salida_bcd     = bus.habilitar_salida ? salida_reg : '0;
    assign bus.ocupado        = ocupado_reg;
    assign bus.listo          = listo_reg;
    assign bus.desbordamiento = desb_reg;
endmodule

// File: tb/tb_conversor_bin2bcd_secuencial.sv
// Self-checking bench for conversor_bin2bcd_secuencial: directed vector table,
// hand-written corner sequences and random operands against a decimal model.
module tb_conversor_bin2bcd_secuencial;
    logic reloj;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [15:0] prev_bcd;
    logic        prev_ovf;

    conversor_bin2bcd_secuencial_if #(.ANCHO_BIN(14), .DIGITOS(4)) bus ();

    conversor_bin2bcd_secuencial #(.ANCHO_BIN(14), .DIGITOS(4)) dut (
        .reloj (reloj),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    typedef struct {
        logic [13:0] entrada;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    function automatic logic [15:0] ref_bcd(input int v);
        int x;
        logic [15:0] r;
        x = (v > 9999) ? 9999 : v;
        r = '0;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int v);
        return v > 9999;
    endfunction

    task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        n_tests++;
        if (actual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nombre, actual, esperado);
        end
    endtask

    task automatic run_conv(input logic [13:0] v);
        int lat;
        @(posedge reloj);
        bus.entrada = v;
        bus.iniciar = 1'b1;
        @(posedge reloj);
        bus.iniciar = 1'b0;
        check("ocupado_e0", 32'(bus.ocupado), 32'd1);
        check("hold_bcd", 32'(bus.salida_bcd), 32'(prev_bcd));
        check("hold_ovf", 32'(bus.desbordamiento), 32'(prev_ovf));
        lat = 0;
        while (!bus.listo && lat < 40) begin
            @(posedge reloj);
            lat++;
        end
        check("latencia", lat, 14);
        prev_bcd = ref_bcd(int'(v));
        prev_ovf = ref_ovf(int'(v));
        check("bcd_model", 32'(bus.salida_bcd), 32'(prev_bcd));
        check("ovf_model", 32'(bus.desbordamiento), 32'(prev_ovf));
        @(posedge reloj);
        check("listo_1ciclo", 32'(bus.listo), 32'd0);
        check("ocupado_fin", 32'(bus.ocupado), 32'd0);
    endtask

    initial begin
        vec_t tabla[8];
        int   pulsos;
        int   c1, c2;

        n_tests = 0;
        n_fail  = 0;
        tabla[0] = '{14'd0,     16'h0000, 1'b0};
        tabla[1] = '{14'd1234,  16'h1234, 1'b0};
        tabla[2] = '{14'd9999,  16'h9999, 1'b0};
        tabla[3] = '{14'd10,    16'h0010, 1'b0};
        tabla[4] = '{14'd16383, 16'h9999, 1'b1};
        tabla[5] = '{14'd5,     16'h0005, 1'b0};
        tabla[6] = '{14'd10000, 16'h9999, 1'b1};
        tabla[7] = '{14'd567,   16'h0567, 1'b0};

        bus.iniciar          = 1'b0;
        bus.entrada          = '0;
        bus.habilitar_salida = 1'b1;
        reset                = 1'b1;
        repeat (3) @(posedge reloj);
        reset = 1'b0;
        @(posedge reloj);
        prev_bcd = '0;
        prev_ovf = 1'b0;
        check("rst_bcd", 32'(bus.salida_bcd), 32'd0);
        check("rst_ocupado", 32'(bus.ocupado), 32'd0);
        check("rst_listo", 32'(bus.listo), 32'd0);
        check("rst_ovf", 32'(bus.desbordamiento), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_conv(tabla[i].entrada);
            check("tabla_bcd", 32'(bus.salida_bcd), 32'(tabla[i].bcd));
            check("tabla_ovf", 32'(bus.desbordamiento), 32'(tabla[i].ovf));
        end

        // last table entry leaves 0x0567: output enable is purely combinational
        bus.habilitar_salida = 1'b0;
        #1;
        check("oe_off", 32'(bus.salida_bcd), 32'd0);
        bus.habilitar_salida = 1'b1;
        #1;
        check("oe_on", 32'(bus.salida_bcd), 32'h0567);

        // second iniciar during DESPLAZAR is ignored, not queued
        @(posedge reloj);
        bus.entrada = 14'd4321;
        bus.iniciar = 1'b1;
        @(posedge reloj);
        bus.iniciar = 1'b0;
        repeat (4) @(posedge reloj);
        bus.entrada = 14'd7;
        bus.iniciar = 1'b1;
        @(posedge reloj);
        bus.iniciar = 1'b0;
        pulsos = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge reloj);
            if (bus.listo) pulsos++;
        end
        check("ignorado_pulsos", pulsos, 1);
        check("ignorado_bcd", 32'(bus.salida_bcd), 32'h4321);
        check("ignorado_ocupado", 32'(bus.ocupado), 32'd0);
        prev_bcd = 16'h4321;
        prev_ovf = 1'b0;

        // held iniciar restarts at the first REPOSO edge: one result per 16 edges
        @(posedge reloj);
        bus.entrada = 14'd100;
        bus.iniciar = 1'b1;
        c1 = -1;
        c2 = -1;
        for (int c = 0; c < 50; c++) begin
            @(posedge reloj);
            if (bus.listo) begin
                if (c1 < 0) c1 = c;
                else if (c2 < 0) c2 = c;
            end
        end
        bus.iniciar = 1'b0;
        check("continuo_primero", c1, 14);
        check("continuo_periodo", c2 - c1, 16);
        repeat (20) @(posedge reloj);
        check("continuo_bcd", 32'(bus.salida_bcd), 32'h0100);
        prev_bcd = 16'h0100;

        // reset mid-conversion aborts and clears the result
        @(posedge reloj);
        bus.entrada = 14'd4321;
        bus.iniciar = 1'b1;
        @(posedge reloj);
        bus.iniciar = 1'b0;
        repeat (5) @(posedge reloj);
        reset = 1'b1;
        @(posedge reloj);
        reset = 1'b0;
        check("abort_ocupado", 32'(bus.ocupado), 32'd0);
        check("abort_bcd", 32'(bus.salida_bcd), 32'd0);
        pulsos = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge reloj);
            if (bus.listo) pulsos++;
        end
        check("abort_sin_listo", pulsos, 0);
        check("abort_bcd_final", 32'(bus.salida_bcd), 32'd0);
        prev_bcd = '0;
        prev_ovf = 1'b0;
        run_conv(14'd88);
        check("tras_abort_bcd", 32'(bus.salida_bcd), 32'h0088);

        // random operands, biased half the time to the saturation boundary
        for (int i = 0; i < 30; i++) begin
            logic [13:0] v;
            if (i % 2 == 0) v = 14'($urandom_range(0, 16383));
            else            v = 14'($urandom_range(9990, 10010));
            run_conv(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
